// File: rtl/hdc_assoc_pkg.sv
// Shared types and helpers for the hypervector associative-search stage.
package hdc_assoc_pkg;

    localparam int unsigned DEF_W_BITS      = 64;
    localparam int unsigned DEF_NUM_CLASSES = 8;
    localparam int unsigned DEF_NUM_FRAMES  = 3;

    // Width needed to hold a full-hypervector Hamming distance (0..frames*width).
    function automatic int unsigned dist_w(input int unsigned frames, input int unsigned width);
        return $clog2(frames * width + 1);
    endfunction

    localparam int unsigned DEF_DIST_W = dist_w(DEF_NUM_FRAMES, DEF_W_BITS);

    typedef logic [DEF_W_BITS-1:0] frame_t;
    typedef logic [DEF_DIST_W-1:0] dist_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/hvec_popcount.sv
// Combinational popcount built as a recursive balanced adder tree.
module hvec_popcount #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0]             bits_i,
    output logic [$clog2(W+1)-1:0]   count_c
);

    localparam int unsigned CW = $clog2(W + 1);

    generate
        if (W == 1) begin : g_leaf
            assign count_c = bits_i;
        end else begin : g_node
            localparam int unsigned WL = W / 2;
            localparam int unsigned WH = W - WL;
            localparam int unsigned CL = $clog2(WL + 1);
            localparam int unsigned CH = $clog2(WH + 1);

            logic [CL-1:0] cnt_lo;
            logic [CH-1:0] cnt_hi;

            hvec_popcount #(.W(WL)) u_lo (
                .bits_i  (bits_i[WL-1:0]),
                .count_c (cnt_lo)
            );

            hvec_popcount #(.W(WH)) u_hi (
                .bits_i  (bits_i[W-1:WL]),
                .count_c (cnt_hi)
            );

            assign count_c = CW'(cnt_lo) + CW'(cnt_hi);
        end
    endgenerate

endmodule

// File: rtl/hvec_assoc_search.sv
// Buffers one framed query, sweeps all (class, frame) generator addresses and reports the nearest class.
// Optional ASSOC_MARGIN_EN adds second_dist / low_conf confidence outputs.
module hvec_assoc_search
    import hdc_assoc_pkg::*;
#(
    parameter int unsigned DI_PARALLEL_W_BITS = DEF_W_BITS,
    parameter int unsigned NUM_CLASSES        = DEF_NUM_CLASSES,
    parameter int unsigned NUM_FRAMES         = DEF_NUM_FRAMES,
`ifdef ASSOC_MARGIN_EN
    parameter int unsigned MARGIN_TH          = 4,
`endif
    localparam int unsigned ID_W   = $clog2(NUM_CLASSES),
    localparam int unsigned DIST_W = dist_w(NUM_FRAMES, DI_PARALLEL_W_BITS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          query_valid,
    output logic                          query_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0] query_frame,
    output logic [ID_W-1:0]               frame_id,
    output logic [1:0]                    frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [ID_W-1:0]               pred_class,
`ifdef ASSOC_MARGIN_EN
    output logic [DIST_W-1:0]             second_dist,
    output logic                          low_conf,
`endif
    output logic [DIST_W-1:0]             best_dist
);

    localparam int unsigned PC_W     = $clog2(DI_PARALLEL_W_BITS + 1);
    localparam logic [1:0]      LAST_FRM = 2'(NUM_FRAMES - 1);
    localparam logic [ID_W-1:0] LAST_CLS = ID_W'(NUM_CLASSES - 1);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    state_e                        state_q, state_d;
    logic [1:0]                    fcnt_q, fcnt_d;
    logic [ID_W-1:0]               cls_q, cls_d;
    logic [1:0]                    frm_q, frm_d;
    logic                          drain_q, drain_d;
    logic                          beat_c;
    logic                          enter_done_c;
    logic                          done_hs_c;

    logic [DI_PARALLEL_W_BITS-1:0] qbuf_q [NUM_FRAMES];
    logic [PC_W-1:0]               pc_c;

    logic                          s1_valid_q;
    logic [PC_W-1:0]               s1_pc_q;
    logic                          s1_last_q;
    logic [ID_W-1:0]               s1_cls_q;

    logic [DIST_W-1:0]             dist_c;
    logic [DIST_W-1:0]             acc_q;
    logic [DIST_W-1:0]             best_q;
    logic [ID_W-1:0]               pred_q;

    logic                          query_ready_q;
    logic                          result_valid_q;
    logic [ID_W-1:0]               pred_class_q;
    logic [DIST_W-1:0]             best_dist_q;

`ifdef ASSOC_MARGIN_EN
    logic [DIST_W-1:0]             second_q;
    logic [DIST_W-1:0]             second_dist_q;
    logic                          low_conf_q;

    assign second_dist = second_dist_q;
    assign low_conf    = low_conf_q;
`endif

    assign query_ready  = query_ready_q;
    assign result_valid = result_valid_q;
    assign pred_class   = pred_class_q;
    assign best_dist    = best_dist_q;
    assign frame_id     = cls_q;
    assign frame_index  = frm_q;

    // State and address/beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= LOAD;
            fcnt_q         <= 2'd0;
            cls_q          <= '0;
            frm_q          <= 2'd0;
            drain_q        <= 1'b0;
            query_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            cls_q          <= cls_d;
            frm_q          <= frm_d;
            drain_q        <= drain_d;
            query_ready_q  <= (state_d == LOAD);
            result_valid_q <= (state_d == DONE);
        end
    end

    // Next-state, sweep address and handshake decode.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        cls_d        = cls_q;
        frm_d        = frm_q;
        drain_d      = drain_q;
        beat_c       = 1'b0;
        done_hs_c    = 1'b0;

        case (state_q)
            LOAD: begin
                if (query_valid && query_ready_q) begin
                    beat_c = 1'b1;
                    if (fcnt_q == LAST_FRM) begin
                        fcnt_d  = 2'd0;
                        cls_d   = '0;
                        frm_d   = 2'd0;
                        state_d = SEARCH;
                    end else begin
                        fcnt_d = fcnt_q + 2'd1;
                    end
                end
            end
            SEARCH: begin
                if (frm_q == LAST_FRM) begin
                    if (cls_q == LAST_CLS) begin
                        drain_d = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        cls_d = cls_q + ID_W'(1);
                        frm_d = 2'd0;
                    end
                end else begin
                    frm_d = frm_q + 2'd1;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready && result_valid_q) begin
                    done_hs_c = 1'b1;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        enter_done_c = (state_q == DRAIN) && (state_d == DONE);
    end

    // Query buffer; stale beats are harmless because fcnt restarts at 0.
    always_ff @(posedge clk) begin
        if (beat_c) begin
            qbuf_q[fcnt_q] <= query_frame;
        end
    end

    hvec_popcount #(.W(DI_PARALLEL_W_BITS)) u_popcount (
        .bits_i  (qbuf_q[frm_q] ^ class_vec_in),
        .count_c (pc_c)
    );

    // Stage 1: per-frame Hamming distance tagged with class and last-frame flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_last_q  <= 1'b0;
            s1_cls_q   <= '0;
        end else begin
            s1_valid_q <= (state_q == SEARCH);
            s1_pc_q    <= pc_c;
            s1_last_q  <= (frm_q == LAST_FRM);
            s1_cls_q   <= cls_q;
        end
    end

    assign dist_c = acc_q + DIST_W'(s1_pc_q);

    // Stage 2: accumulate per class; strict less-than keeps the lower index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            best_q   <= DIST_MAX;
            pred_q   <= '0;
`ifdef ASSOC_MARGIN_EN
            second_q <= DIST_MAX;
`endif
        end else begin
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    acc_q <= '0;
                    if (dist_c < best_q) begin
                        best_q   <= dist_c;
                        pred_q   <= s1_cls_q;
`ifdef ASSOC_MARGIN_EN
                        second_q <= best_q;
                    end else if (dist_c < second_q) begin
                        second_q <= dist_c;
`endif
                    end
                end else begin
                    acc_q <= dist_c;
                end
            end
            if (done_hs_c) begin
                best_q   <= DIST_MAX;
`ifdef ASSOC_MARGIN_EN
                second_q <= DIST_MAX;
`endif
            end
        end
    end

    // Result registers, frozen for the whole DONE phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_class_q  <= '0;
            best_dist_q   <= '0;
`ifdef ASSOC_MARGIN_EN
            second_dist_q <= '0;
            low_conf_q    <= 1'b0;
`endif
        end else if (enter_done_c) begin
            pred_class_q  <= pred_q;
            best_dist_q   <= best_q;
`ifdef ASSOC_MARGIN_EN
            second_dist_q <= second_q;
            low_conf_q    <= ((second_q - best_q) < DIST_W'(MARGIN_TH));
        end else if (done_hs_c) begin
            low_conf_q    <= 1'b0;
`endif
        end
    end

endmodule

// File: doc/hvec_assoc_search.md
Name: hvec_assoc_search

Overview:
Associative-search stage that sits directly downstream of the class hypervector generator. It buffers one framed query hypervector and sweeps every (class, frame) address of the generator. For each class it accumulates the Hamming distance between the query and the class vector. It then emits the index of the nearest class, which is the inference result.

Parameters:
DI_PARALLEL_W_BITS, 64, frame width in bits; must match the generator
NUM_CLASSES, 8, number of classes swept; frame_id width = clog2(NUM_CLASSES)
NUM_FRAMES, 3, frames per hypervector; frame_index width = 2
DIST_W, clog2(NUM_FRAMES*DI_PARALLEL_W_BITS+1) = 8, distance width (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
query_valid  in  1  query frame beat valid
query_ready  out  1  query frame beat accepted when valid&ready
query_frame  in  DI_PARALLEL_W_BITS  query frame data, sent frame 0 first
frame_id  out  clog2(NUM_CLASSES)  class address to the generator
frame_index  out  2  frame address to the generator
class_vec_in  in  DI_PARALLEL_W_BITS  generator output; combinational, same cycle as the address
result_valid  out  1  prediction available
result_ready  in  1  consumer accepts the prediction
pred_class  out  clog2(NUM_CLASSES)  index of the nearest class
best_dist  out  DIST_W  Hamming distance of the nearest class

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - State LOAD; query_ready=1; result_valid=0.
  - pred_class=0, best_dist=0; frame_id=0, frame_index=0.
  - Internal accumulators 0; best register all-ones.
- FSM states LOAD → SEARCH → DRAIN → DONE → LOAD.
- LOAD:
  - query_ready=1.
  - Each handshake stores the beat into qbuf[fcnt] and increments fcnt.
  - On the handshake with fcnt==NUM_FRAMES-1, go to SEARCH; fcnt wraps to 0.
- SEARCH:
  - query_ready=0.
  - Address counter (cls, frm) drives frame_id/frame_index.
  - Sweep order is frm fastest: (0,0),(0,1),(0,2),(1,0)…, one address per cycle.
  - Stage 1 (registered): pc = popcount(qbuf[frm] ^ class_vec_in), plus a last_frm flag and the class tag.
  - Stage 2 (registered): dist = acc + pc.
    - If last_frm: compare dist against best. Strictly-less updates best/pred; ties keep the lower index. Then clear acc.
    - Otherwise acc = dist.
  - After address (NUM_CLASSES-1, NUM_FRAMES-1), go to DRAIN.
- DRAIN: two cycles to flush stages 1 and 2, then go to DONE.
- DONE:
  - result_valid=1; pred_class/best_dist stable until result_ready.
  - Handshake → LOAD, best reset to all-ones, query_ready=1 from the next cycle.
  - query_valid during DONE is ignored; the query is taken in LOAD.
- Latency: result_valid rises NUM_CLASSES*NUM_FRAMES+2 cycles after the last query handshake (26 cycles at defaults).
- Sweep throughput: 1 address/cycle, no stalls. class_vec_in is never backpressured.
- Widths: pc width clog2(W+1); acc/best width DIST_W. No overflow is possible by construction.
- frame_id/frame_index hold the last address outside SEARCH.
- rst in any state aborts the operation. The next cycle shows reset values, and partial query beats are discarded.

Optional Feature:
Macro ASSOC_MARGIN_EN.
- Defined:
  - Adds output second_dist [DIST_W], the second-smallest class distance, using the same tie rule.
  - Adds output low_conf [1], asserted with result_valid when second_dist-best_dist < MARGIN_TH.
  - MARGIN_TH is a parameter, default 4.
  - Both outputs reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hdc_assoc_pkg:
  - state enum {LOAD, SEARCH, DRAIN, DONE}.
  - Function dist_w(frames, width).
  - Shared typedefs: frame_t = logic[DI_PARALLEL_W_BITS-1:0], dist_t.
- Sub-module hvec_popcount:
  - Combinational adder-tree popcount, parameterized on width.
  - Instanced once in stage 1.

Test Plan:
- Exact match:
  - Stimulus: stub generator table; query = class 3's three frames.
  - Response: pred_class=3, best_dist=0; result_valid 26 cycles after the third beat.
- Inverse:
  - Stimulus: query = bitwise NOT of class 5's frames; other classes random.
  - Response: class 5 distance = 192 and never selected. pred_class equals the reference-model argmin.
- Tie:
  - Stimulus: classes 2 and 6 identical in the stub; query equals them.
  - Response: pred_class=2, best_dist=0.
- Backpressure:
  - Stimulus: hold result_ready=0 for 10 cycles; drive query_valid=1 throughout.
  - Response: outputs stable, query_ready=0. After the handshake, the next query is accepted from the following cycle.
- Mid-search reset:
  - Stimulus: assert rst for one cycle at sweep cycle 10.
  - Response: next cycle result_valid=0, query_ready=1. A fresh query then yields the correct result with no stale accumulation.
- Beat gaps:
  - Stimulus: query_valid toggled 1,0,0,1,0,1.
  - Response: exactly three beats stored in order; search starts the cycle after the third handshake.
